rms_unit: RTL

Downstream consumer of the sum-of-squares datapath. Takes the final 28-bit Result (sum of squared samples) and the 8-bit Len (element count) once the list walk completes. Computes the mean square (Result / Len) and its integer square root (RMS) using multi-cycle sequential arithmetic, then presents both with a one-cycle Valid pulse.

---
 rtl/rms_pkg.sv | 18 +
 rtl/rms_if.sv | 40 ++++
 rtl/seq_divider.sv | 61 ++++++
 rtl/rms_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rms_pkg.sv
// rms_pkg: shared constants and the FSM state type for the RMS unit.
//   SUM_W  : width of the sum-of-squares input and the mean output
//   LEN_W  : width of the element count input
//   ROOT_W : width of the square-root output (SUM_W/2)
package rms_pkg;

  localparam int SUM_W  = 28;
  localparam int LEN_W  = 8;
  localparam int ROOT_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rms_if.sv
// rms_if: job/result bundle between the sum-of-squares datapath and rms_unit.
//   Start   : one-cycle strobe, Sum/Len valid in that cycle (master -> slave)
//   Sum/Len : job operands (master -> slave)
//   Busy    : unit is iterating (DIV or SQRT)
//   Valid   : one-cycle pulse, Mean/Root/DivZero freshly updated
//   DivZero/Mean/Root : results of the last accepted job
//   State   : FSM state, exported for debug/checkers
//
// Handshake: Start is a request strobe with no ready signal. It is honoured
// only when Busy is low (IDLE or DONE); a Start seen while Busy is high is
// dropped entirely. Valid is high for exactly one cycle per accepted job and
// the results hold until the next Valid or Reset.
interface rms_if #(
  parameter int SUM_W  = rms_pkg::SUM_W,
  parameter int LEN_W  = rms_pkg::LEN_W,
  parameter int ROOT_W = rms_pkg::ROOT_W
) ();
  import rms_pkg::*;

  logic              Start;
  logic [SUM_W-1:0]  Sum;
  logic [LEN_W-1:0]  Len;
  logic              Busy;
  logic              Valid;
  logic              DivZero;
  logic [SUM_W-1:0]  Mean;
  logic [ROOT_W-1:0] Root;
  state_t            State;

  modport master (
    output Start, Sum, Len,
    input  Busy, Valid, DivZero, Mean, Root, State
  );

  modport slave (
    input  Start, Sum, Len,
    output Busy, Valid, DivZero, Mean, Root, State
  );

endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, MSB
// first. The dividend register shifts left and collects quotient bits in its
// LSB, so after SUM_W steps it holds floor(Sum/Len); the remainder is dropped.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   i_start    : load operands (Sum, Len) this cycle
//   i_sum/i_len: dividend / divisor
//   i_step     : perform one division step this cycle
//   i_iter     : shared iteration count, 0..SUM_W-1 across the steps
//   o_done     : this cycle's step is the last one
//   o_quot     : quotient, stable once the last step has been taken
module seq_divider #(
  parameter int SUM_W  = 28,
  parameter int LEN_W  = 8,
  parameter int ITER_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_start,
  input  logic [SUM_W-1:0]  i_sum,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_step,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_done,
  output logic [SUM_W-1:0]  o_quot
);

  logic [SUM_W-1:0] r_work;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_divisor;

  logic [LEN_W:0]   w_trial;
  logic             w_fit;
  logic [LEN_W-1:0] w_rem_next;

  // Working remainder is LEN_W+1 bits wide while shifting; the stored value
  // is always below the divisor, so LEN_W bits are enough between steps.
  assign w_trial    = {r_rem, r_work[SUM_W-1]};
  assign w_fit      = (w_trial >= {1'b0, r_divisor});
  assign w_rem_next = w_fit ? LEN_W'(w_trial - {1'b0, r_divisor})
                            : LEN_W'(w_trial);

  assign o_done = i_step && (i_iter == ITER_W'(SUM_W - 1));
  assign o_quot = r_work;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_work    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_work    <= i_sum;
      r_rem     <= '0;
      r_divisor <= i_len;
    end else if (i_step) begin
      r_work <= {r_work[SUM_W-2:0], w_fit};
      r_rem  <= w_rem_next;
    end
  end

endmodule

// File: rtl/rms_unit.sv
// rms_unit: computes Mean = floor(Sum/Len) and Root = floor(sqrt(Mean)) with
// multi-cycle arithmetic: SUM_W clocks of restoring division followed by
// ROOT_W clocks of digit-by-digit square root, then a one-cycle Valid.
// Ports:
//   Clk   : clock
//   Reset : synchronous, active-high reset
//   bus   : rms_if slave (Start/Sum/Len in; Busy/Valid/DivZero/Mean/Root/State out)
module rms_unit
  import rms_pkg::*;
#(
  parameter int SUM_W  = rms_pkg::SUM_W,
  parameter int LEN_W  = rms_pkg::LEN_W,
  parameter int ROOT_W = rms_pkg::ROOT_W
) (
  input  logic Clk,
  input  logic Reset,
  rms_if.slave bus
);

  localparam int ITER_W = $clog2(SUM_W);
  localparam int SH_W   = ITER_W + 1;
  localparam int REM_W  = ROOT_W + 3;

  state_t              r_state;
  state_t              w_next;
  logic [ITER_W-1:0]   r_iter;   // shared by DIV and SQRT
  logic [ROOT_W-1:0]   r_root;   // partial root
  logic [ROOT_W:0]     r_rem;    // partial remainder, never exceeds 2*root
  logic [SUM_W-1:0]    r_mean;
  logic [ROOT_W-1:0]   r_root_out;
  logic                r_div_zero;

  logic                w_accept;
  logic                w_len_zero;
  logic                w_div_step;
  logic                w_div_done;
  logic [SUM_W-1:0]    w_quot;
  logic [SH_W-1:0]     w_shamt;
  logic [1:0]          w_pair;
  logic [REM_W-1:0]    w_rem_shift;
  logic [REM_W-1:0]    w_trial;
  logic                w_ge;
  logic [ROOT_W:0]     w_rem_next;
  logic [ROOT_W-1:0]   w_root_next;
  logic                w_sqrt_last;

  // New jobs are only taken when not iterating; DONE accepts back-to-back.
  assign w_accept   = bus.Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_len_zero = (bus.Len == '0);
  assign w_div_step = (r_state == DIV);

  seq_divider #(
    .SUM_W  (SUM_W),
    .LEN_W  (LEN_W),
    .ITER_W (ITER_W)
  ) u_div (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_start (w_accept && !w_len_zero),
    .i_sum   (bus.Sum),
    .i_len   (bus.Len),
    .i_step  (w_div_step),
    .i_iter  (r_iter),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  // Square root consumes the held quotient two bits per clock, MSB pair first;
  // the pair is picked by the iteration count rather than shifting a copy.
  assign w_shamt     = SH_W'(SUM_W - 2) - {r_iter, 1'b0};
  assign w_pair      = 2'(w_quot >> w_shamt);
  assign w_rem_shift = {r_rem, w_pair};
  assign w_trial     = REM_W'({r_root, 2'b01});
  assign w_ge        = (w_rem_shift >= w_trial);
  assign w_rem_next  = w_ge ? (ROOT_W + 1)'(w_rem_shift - w_trial)
                            : (ROOT_W + 1)'(w_rem_shift);
  assign w_root_next = {r_root[ROOT_W-2:0], w_ge};
  assign w_sqrt_last = (r_iter == ITER_W'(ROOT_W - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_len_zero ? DONE : DIV;
      DIV:  if (w_div_done) w_next = SQRT;
      SQRT: if (w_sqrt_last) w_next = DONE;
      DONE: begin
        if (w_accept) w_next = w_len_zero ? DONE : DIV;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_iter     <= '0;
      r_root     <= '0;
      r_rem      <= '0;
      r_mean     <= '0;
      r_root_out <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_iter <= '0;
            r_root <= '0;
            r_rem  <= '0;
            // A zero count skips the arithmetic and publishes zeros at once.
            if (w_len_zero) begin
              r_mean     <= '0;
              r_root_out <= '0;
              r_div_zero <= 1'b1;
            end
          end
        end
        DIV: begin
          r_iter <= w_div_done ? '0 : r_iter + ITER_W'(1);
        end
        SQRT: begin
          r_iter <= r_iter + ITER_W'(1);
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          if (w_sqrt_last) begin
            r_mean     <= w_quot;
            r_root_out <= w_root_next;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = (r_state == DIV) || (r_state == SQRT);
  assign bus.Valid   = (r_state == DONE);
  assign bus.DivZero = r_div_zero;
  assign bus.Mean    = r_mean;
  assign bus.Root    = r_root_out;
  assign bus.State   = r_state;

endmodule
